// File: rtl/gpio_irq_if.sv
// AXI4-Lite bus bundle used by the GPIO peripheral.
// aclk/areset_n are carried for the bus fabric; the GPIO block is clocked from its own ports.
interface axi4_lite #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic              aclk;
    logic              areset_n;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH/8-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [WIDTH-1:0]  rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport subordinate (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/gpio_irq.sv
// AXI4-Lite GPIO: tristate pins, synchronised inputs, atomic set/clear, sticky per-channel interrupts.
// Define GPIO_DEBOUNCE_EN to insert a per-pin debounce filter between synchroniser and IDATA.
module gpio_irq #(
    parameter int WIDTH        = 32,
    parameter int PIN_COUNT    = 16,
    parameter int NUM_IRQ      = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    inout  wire  [PIN_COUNT-1:0] io_pins,
    output logic [NUM_IRQ-1:0]   irq,
    axi4_lite.subordinate        axi
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [PIN_COUNT-1:0] sync_q [SYNC_STAGES];
    logic [PIN_COUNT-1:0] sync_d [SYNC_STAGES];
    logic [PIN_COUNT-1:0] mode_q, mode_d, odata_q, odata_d, idata;
    logic [NUM_IRQ-1:0]   pend_q, pend_d, prev_q, prev_d, arm_q, arm_d, evt, cur, pin_ok;
    logic [2:0]           cfg_mode_q [NUM_IRQ];
    logic [2:0]           cfg_mode_d [NUM_IRQ];
    logic [4:0]           cfg_pin_q  [NUM_IRQ];
    logic [4:0]           cfg_pin_d  [NUM_IRQ];
    logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic                 arready_q, arready_d, rvalid_q, rvalid_d, wr_commit;
    logic [7:0]           awaddr_q, awaddr_d, ar;
    logic [WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d, rd_data;
    logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]          idata_ext;
    logic                 unused_ok;

    function automatic logic is_icfg(input logic [7:0] a);
        return (a[7:5] == 3'b001) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic rd_ok(input logic [7:0] a);
        return is_icfg(a) || (a inside {8'h00, 8'h04, 8'h08, 8'h14});
    endfunction

    function automatic logic wr_ok(input logic [7:0] a);
        return is_icfg(a) || (a inside {8'h00, 8'h08, 8'h0C, 8'h10, 8'h14});
    endfunction

    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_pad
        assign io_pins[i] = mode_q[i] ? odata_q[i] : 1'bz;
    end

    always_comb begin
        sync_d[0] = io_pins;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    logic [PIN_COUNT-1:0] idata_q, idata_d;
    logic [CNT_W-1:0]     cnt_q [PIN_COUNT];
    logic [CNT_W-1:0]     cnt_d [PIN_COUNT];

    // A pin must disagree with IDATA for DEBOUNCE_CYC consecutive cycles; any agreement restarts.
    always_comb begin
        idata_d = idata_q;
        for (int i = 0; i < PIN_COUNT; i++) begin
            cnt_d[i] = '0;
            if (sync_q[SYNC_STAGES-1][i] != idata_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) idata_d[i] = sync_q[SYNC_STAGES-1][i];
                else                                      cnt_d[i]   = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            idata_q <= '0;
            for (int i = 0; i < PIN_COUNT; i++) cnt_q[i] <= '0;
        end else begin
            idata_q <= idata_d;
            for (int i = 0; i < PIN_COUNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    assign idata = idata_q;
`else
    assign idata = sync_q[SYNC_STAGES-1];
`endif

    assign idata_ext = 32'(idata);
    assign irq       = pend_q;
    assign unused_ok = ^{axi.awaddr, axi.araddr, axi.wstrb, wdata_q};

    always_comb begin
        for (int k = 0; k < NUM_IRQ; k++) begin
            pin_ok[k] = int'(cfg_pin_q[k]) < PIN_COUNT;
            cur[k]    = pin_ok[k] & idata_ext[cfg_pin_q[k]];
            case (cfg_mode_q[k])
                3'b100:  evt[k] = cur[k] & ~prev_q[k];
                3'b101:  evt[k] = ~cur[k] & prev_q[k];
                3'b110:  evt[k] = cur[k];
                3'b111:  evt[k] = ~cur[k];
                3'b001:  evt[k] = cur[k] ^ prev_q[k];
                default: evt[k] = 1'b0;
            endcase
            evt[k] = evt[k] & arm_q[k] & pin_ok[k];
        end
    end

    always_comb begin
        ar        = axi.araddr[7:0];
        rd_data   = '0;
        if (rd_ok(ar)) begin
            case (ar)
                8'h00:   rd_data = WIDTH'(mode_q);
                8'h04:   rd_data = WIDTH'(idata);
                8'h08:   rd_data = WIDTH'(odata_q);
                8'h14:   rd_data = WIDTH'(pend_q);
                default: for (int k = 0; k < NUM_IRQ; k++)
                    if (ar[4:2] == 3'(k)) rd_data = WIDTH'({cfg_pin_q[k], 5'b0, cfg_mode_q[k]});
            endcase
        end

        arready_d = arready_q; rvalid_d = rvalid_q; rdata_d = rdata_q; rresp_d = rresp_q;
        if (rvalid_q) begin
            if (axi.rready) begin
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
            end
        end else if (arready_q && axi.arvalid) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = rd_data;
            rresp_d   = rd_ok(ar) ? RESP_OKAY : RESP_SLVERR;
        end

        awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q; bresp_d = bresp_q;
        awaddr_d  = awaddr_q;  wdata_d  = wdata_q;
        mode_d    = mode_q;    odata_d  = odata_q; pend_d = pend_q;
        prev_d    = cur;       arm_d    = '1;
        cfg_mode_d = cfg_mode_q;
        cfg_pin_d  = cfg_pin_q;
        if (awready_q && axi.awvalid) begin
            awready_d = 1'b0;
            awaddr_d  = axi.awaddr[7:0];
        end
        if (wready_q && axi.wvalid) begin
            wready_d = 1'b0;
            wdata_d  = axi.wdata;
        end
        if (bvalid_q && axi.bready) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end

        // Both halves held and no response outstanding: commit exactly once.
        wr_commit = !awready_q && !wready_q && !bvalid_q;
        if (wr_commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok(awaddr_q)) begin
                case (awaddr_q)
                    8'h00:   mode_d  = wdata_q[PIN_COUNT-1:0];
                    8'h08:   odata_d = wdata_q[PIN_COUNT-1:0];
                    8'h0C:   odata_d = odata_q | wdata_q[PIN_COUNT-1:0];
                    8'h10:   odata_d = odata_q & ~wdata_q[PIN_COUNT-1:0];
                    8'h14:   pend_d  = pend_q & ~wdata_q[NUM_IRQ-1:0];
                    default: for (int k = 0; k < NUM_IRQ; k++)
                        if (awaddr_q[4:2] == 3'(k)) begin
                            cfg_mode_d[k] = wdata_q[2:0];
                            cfg_pin_d[k]  = wdata_q[12:8];
                            arm_d[k]      = 1'b0;
                        end
                endcase
            end
        end
        // New events beat a W1C on the same bit; reconfiguration clears its own channel.
        pend_d = (pend_d | evt) & arm_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int k = 0; k < NUM_IRQ; k++) begin
                cfg_mode_q[k] <= '0;
                cfg_pin_q[k]  <= '0;
            end
            mode_q <= '0; odata_q <= '0; pend_q <= '0; prev_q <= '0; arm_q <= '0;
            awready_q <= 1'b1; wready_q <= 1'b1; bvalid_q <= 1'b0; bresp_q <= RESP_OKAY;
            arready_q <= 1'b1; rvalid_q <= 1'b0; rresp_q <= RESP_OKAY; rdata_q <= '0;
            awaddr_q  <= '0;   wdata_q  <= '0;
        end else begin
            sync_q     <= sync_d;
            cfg_mode_q <= cfg_mode_d;
            cfg_pin_q  <= cfg_pin_d;
            mode_q <= mode_d; odata_q <= odata_d; pend_q <= pend_d; prev_q <= prev_d; arm_q <= arm_d;
            awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d; bresp_q <= bresp_d;
            arready_q <= arready_d; rvalid_q <= rvalid_d; rresp_q <= rresp_d; rdata_q <= rdata_d;
            awaddr_q  <= awaddr_d;  wdata_q  <= wdata_d;
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rresp   = rresp_q;
    assign axi.rdata   = rdata_q;
endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: bus handshakes, pads, atomic updates, interrupt channels, errors.
`timescale 1ns/1ps
module tb_gpio_irq;
    localparam int PIN_COUNT = 16, NUM_IRQ = 4, SYNC_STAGES = 2, DEBOUNCE_CYC = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SYNC_STAGES + DEBOUNCE_CYC + 1;
`else
    localparam int LAT = SYNC_STAGES + 1;
`endif

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    wire  [PIN_COUNT-1:0] io_pins;
    logic [NUM_IRQ-1:0]   irq;
    logic [PIN_COUNT-1:0] tb_oe, tb_val;
    int                   compared = 0, mismatched = 0;
    logic [31:0]          rd;
    logic [1:0]           rs, ws;

    axi4_lite #(.WIDTH(32)) axi();

    gpio_irq #(.WIDTH(32), .PIN_COUNT(PIN_COUNT), .NUM_IRQ(NUM_IRQ),
               .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
        .aclk(aclk), .areset(areset), .io_pins(io_pins), .irq(irq), .axi(axi));

    always #5 aclk = ~aclk;
    assign axi.aclk     = aclk;
    assign axi.areset_n = ~areset;

    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_drv
        assign io_pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, output logic [1:0] resp);
        bit awh, wh, bh, done;
        resp = 2'bxx; done = 0;
        axi.awaddr = {24'h0, addr}; axi.awvalid = 1; axi.wdata = data; axi.wvalid = 1; axi.bready = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            awh = axi.awvalid && axi.awready;
            wh  = axi.wvalid && axi.wready;
            bh  = axi.bvalid && axi.bready;
            if (bh) resp = axi.bresp;
            tick(1);
            if (awh) axi.awvalid = 0;
            if (wh)  axi.wvalid = 0;
            if (bh)  begin axi.bready = 0; done = 1; end
        end
        axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit arh, rh, done;
        data = 'x; resp = 2'bxx; done = 0;
        axi.araddr = {24'h0, addr}; axi.arvalid = 1; axi.rready = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            arh = axi.arvalid && axi.arready;
            rh  = axi.rvalid && axi.rready;
            if (rh) begin data = axi.rdata; resp = axi.rresp; end
            tick(1);
            if (arh) axi.arvalid = 0;
            if (rh)  begin axi.rready = 0; done = 1; end
        end
        axi.arvalid = 0; axi.rready = 0;
    endtask

    task automatic test_reset();
        tick(3); areset = 0;
        compared++; if (irq !== 4'h0) begin mismatched++; $display("FAIL reset_irq: got %h want 0", irq); end
        compared++; if ({axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid} !== 5'b11100) begin
            mismatched++; $display("FAIL reset_hs: got %b want 11100",
                {axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid}); end
        axi_read(8'h00, rd, rs);
        compared++; if ({rs, rd} !== 34'h0) begin mismatched++; $display("FAIL reset_mode: got %h/%h want 0/0", rs, rd); end
        axi_read(8'h08, rd, rs);
        compared++; if ({rs, rd} !== 34'h0) begin mismatched++; $display("FAIL reset_odata: got %h/%h want 0/0", rs, rd); end
        axi_read(8'h14, rd, rs);
        compared++; if ({rs, rd} !== 34'h0) begin mismatched++; $display("FAIL reset_pend: got %h/%h want 0/0", rs, rd); end
    endtask

    task automatic test_output();
        tb_oe = 16'hFFF0; tb_val = 16'hABC0;
        axi_write(8'h00, 32'h0000_000F, ws);
        axi_write(8'h08, 32'h0000_00A5, ws);
        tick(4);
        compared++; if (io_pins[3:0] !== 4'b0101) begin mismatched++; $display("FAIL pads_out: got %b want 0101", io_pins[3:0]); end
        axi_read(8'h04, rd, rs);
        compared++; if (rd !== 32'h0000_ABC5) begin mismatched++; $display("FAIL idata_mix: got %h want 0000abc5", rd); end
        axi_read(8'h08, rd, rs);
        compared++; if ({rs, rd} !== {2'b00, 32'h0000_00A5}) begin mismatched++; $display("FAIL odata_rd: got %h/%h want 0/000000a5", rs, rd); end
        axi_read(8'h00, rd, rs);
        compared++; if (rd !== 32'h0000_000F) begin mismatched++; $display("FAIL mode_rd: got %h want 0000000f", rd); end
    endtask

    task automatic test_atomic();
        axi_write(8'h08, 32'h0000_00F0, ws);
        axi_write(8'h0C, 32'h0000_0003, ws);
        compared++; if (ws !== 2'b00) begin mismatched++; $display("FAIL oset_resp: got %h want 0", ws); end
        axi_write(8'h10, 32'h0000_0010, ws);
        compared++; if (ws !== 2'b00) begin mismatched++; $display("FAIL oclr_resp: got %h want 0", ws); end
        axi_read(8'h08, rd, rs);
        compared++; if (rd !== 32'h0000_00E3) begin mismatched++; $display("FAIL set_clr: got %h want 000000e3", rd); end
        axi_write(8'h08, 32'hFFFF_FFFF, ws);
        axi_read(8'h08, rd, rs);
        compared++; if (rd !== 32'h0000_FFFF) begin mismatched++; $display("FAIL odata_mask: got %h want 0000ffff", rd); end
        axi_read(8'h0C, rd, rs);
        compared++; if ({rs, rd} !== {2'b10, 32'h0}) begin mismatched++; $display("FAIL oset_read: got %h/%h want 2/0", rs, rd); end
    endtask

    task automatic test_edge_irq();
        axi_write(8'h20, 32'h0000_0504, ws);
        tick(3);
        compared++; if (irq[0] !== 1'b0) begin mismatched++; $display("FAIL edge_idle: got %b want 0", irq[0]); end
        tb_val[5] = 1'b1;
        for (int c = 1; c <= LAT; c++) begin
            tick(1);
            if (c >= LAT - 1) begin
                compared++;
                if (irq[0] !== (c == LAT)) begin mismatched++; $display("FAIL edge_lat%0d: got %b want %b", c, irq[0], c == LAT); end
            end
        end
        axi_write(8'h14, 32'h0000_0001, ws);
        compared++; if ({ws, irq[0]} !== 3'b000) begin mismatched++; $display("FAIL edge_w1c: got %h/%b want 0/0", ws, irq[0]); end
        tb_val[5] = 1'b0;
        tick(LAT + 4);
        compared++; if (irq[0] !== 1'b0) begin mismatched++; $display("FAIL edge_fall: got %b want 0", irq[0]); end
    endtask

    task automatic test_level_irq();
        axi_write(8'h00, 32'h0, ws);
        tb_val[3:0] = 4'b0100; tb_oe = '1;
        tick(LAT + 1);
        axi_write(8'h24, 32'h0000_0206, ws);
        tick(3);
        compared++; if (irq[1] !== 1'b1) begin mismatched++; $display("FAIL level_fire: got %b want 1", irq[1]); end
        axi_read(8'h24, rd, rs);
        compared++; if (rd !== 32'h0000_0206) begin mismatched++; $display("FAIL icfg_rd: got %h want 00000206", rd); end
        axi_write(8'h14, 32'h0000_0002, ws);
        tick(2);
        compared++; if (irq[1] !== 1'b1) begin mismatched++; $display("FAIL level_w1c_held: got %b want 1", irq[1]); end
        tb_val[2] = 1'b0;
        tick(LAT + 2);
        compared++; if (irq[1] !== 1'b1) begin mismatched++; $display("FAIL level_sticky: got %b want 1", irq[1]); end
        axi_write(8'h14, 32'h0000_0002, ws);
        compared++; if (irq[1] !== 1'b0) begin mismatched++; $display("FAIL level_clear: got %b want 0", irq[1]); end
    endtask

    task automatic test_reconfig();
        tb_val[10] = 1'b0; tb_val[9] = 1'b1;
        tick(LAT);
        axi_write(8'h28, 32'h0000_0A01, ws);
        tick(4);
        axi_write(8'h28, 32'h0000_0901, ws);
        tick(4);
        compared++; if (irq[2] !== 1'b0) begin mismatched++; $display("FAIL reconfig_spurious: got %b want 0", irq[2]); end
        tb_val[9] = 1'b0;
        tick(LAT);
        compared++; if (irq[2] !== 1'b1) begin mismatched++; $display("FAIL both_edge: got %b want 1", irq[2]); end
        axi_write(8'h2C, 32'h0000_1407, ws);
        tick(6);
        compared++; if (irq[3] !== 1'b0) begin mismatched++; $display("FAIL pin_range: got %b want 0", irq[3]); end
    endtask

    task automatic test_errors();
        axi_read(8'h06, rd, rs);
        compared++; if ({rs, rd} !== {2'b10, 32'h0}) begin mismatched++; $display("FAIL misaligned_rd: got %h/%h want 2/0", rs, rd); end
        axi_write(8'h04, 32'h0000_FFFF, ws);
        compared++; if (ws !== 2'b10) begin mismatched++; $display("FAIL idata_wr_resp: got %h want 2", ws); end
        axi_read(8'h04, rd, rs);
        compared++; if (rd !== {16'h0, tb_val}) begin mismatched++; $display("FAIL idata_unchanged: got %h want %h", rd, {16'h0, tb_val}); end
        axi_read(8'h34, rd, rs);
        compared++; if ({rs, rd} !== 34'h0) begin mismatched++; $display("FAIL icfg_hi_rd: got %h/%h want 0/0", rs, rd); end
        axi_write(8'h34, 32'h0000_0104, ws);
        compared++; if (ws !== 2'b00) begin mismatched++; $display("FAIL icfg_hi_wr: got %h want 0", ws); end
        axi_read(8'h40, rd, rs);
        compared++; if (rs !== 2'b10) begin mismatched++; $display("FAIL unmapped_rd: got %h want 2", rs); end
    endtask

    task automatic test_back_to_back();
        int nb; bit early;
        nb = 0; early = 0;
        axi.wdata = 32'h0000_005A; axi.wvalid = 1; axi.bready = 0;
        tick(1); axi.wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            if (axi.bvalid) early = 1;
            tick(1);
        end
        compared++; if (early !== 1'b0) begin mismatched++; $display("FAIL w_first_early_b: got %b want 0", early); end
        axi.awaddr = 32'h08; axi.awvalid = 1;
        tick(1); axi.awvalid = 0; axi.bready = 1;
        for (int c = 0; c < 10; c++) begin
            if (axi.bvalid && axi.bready) nb++;
            tick(1);
        end
        axi.bready = 0;
        compared++; if (nb !== 1) begin mismatched++; $display("FAIL w_first_bcount: got %0d want 1", nb); end
        axi_read(8'h08, rd, rs);
        compared++; if (rd !== 32'h0000_005A) begin mismatched++; $display("FAIL w_first_data: got %h want 0000005a", rd); end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce();
        axi_write(8'h20, 32'h0000_0C04, ws);
        tick(3);
        tb_val[12] = 1'b1; tick(DEBOUNCE_CYC - 1); tb_val[12] = 1'b0;
        tick(20);
        axi_read(8'h04, rd, rs);
        compared++; if ({rd[12], irq[0]} !== 2'b00) begin mismatched++; $display("FAIL deb_glitch: got %b want 00", {rd[12], irq[0]}); end
        tb_val[12] = 1'b1;
        tick(20);
        axi_read(8'h04, rd, rs);
        compared++; if ({rd[12], irq[0]} !== 2'b11) begin mismatched++; $display("FAIL deb_stable: got %b want 11", {rd[12], irq[0]}); end
    endtask
`endif

    task automatic test_reset_mid();
        axi.awaddr = 32'h08; axi.awvalid = 1; axi.wdata = 32'h33; axi.wvalid = 1; axi.bready = 0;
        tick(1);
        areset = 1;
        tick(1);
        areset = 0; axi.awvalid = 0; axi.wvalid = 0;
        compared++; if ({axi.awready, axi.wready, axi.bvalid, irq} !== 7'b1100000) begin
            mismatched++; $display("FAIL mid_reset_state: got %b want 1100000", {axi.awready, axi.wready, axi.bvalid, irq}); end
        axi_read(8'h08, rd, rs);
        compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL mid_reset_odata: got %h want 0", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wstrb = 4'hF; axi.wvalid = 0;
        axi.bready = 0; axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
        tb_oe = '1; tb_val = '0;
        #1;
        test_reset();
        test_output();
        test_atomic();
        test_edge_irq();
        test_level_irq();
        test_reconfig();
        test_errors();
        test_back_to_back();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
